// File: rtl/shift_left_sequencer.sv
// Clocked controller for the self-timed left-shift register: runs one
// "load, then shift left n times" job per start pulse, with a timeout on each finish handshake.
module shift_left_sequencer #(
  parameter int Width      = 32,
  parameter int AmtWidth   = 6,
  parameter int ReqHold    = 2,
  parameter int SyncStages = 2,
  parameter int Timeout    = 255
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                startReq,
  input  logic [AmtWidth-1:0] amount,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [AmtWidth-1:0] shiftsDone,
  output logic                saveReq,
  input  logic                saveFin,
  output logic                leftReq,
  input  logic                leftFin
);

  localparam int CntW = $clog2(ReqHold + SyncStages + Timeout + 1);
  localparam logic [CntW-1:0]   HoldLast  = CntW'(ReqHold - 1);
  localparam logic [CntW-1:0]   SettleEnd = CntW'(SyncStages);
  localparam logic [CntW-1:0]   CheckLast = CntW'(SyncStages + Timeout - 1);
  localparam logic [AmtWidth:0] WidthMax  = (AmtWidth + 1)'(Width);

  typedef enum logic [2:0] {
    IDLE,
    SAVE_REQ,
    SAVE_WAIT,
    LEFT_REQ,
    LEFT_WAIT,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [AmtWidth:0]     n_q, n_d;
  logic [AmtWidth:0]     shifts_q, shifts_d;
  logic                  err_q, err_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  save_req_q, save_req_d;
  logic                  left_req_q, left_req_d;
  logic [SyncStages-1:0] save_sync_q, save_sync_d;
  logic [SyncStages-1:0] left_sync_q, left_sync_d;
  logic                  fin_sync;
  logic [AmtWidth:0]     shifts_inc;

  assign save_sync_d = {save_sync_q[SyncStages-2:0], saveFin};
  assign left_sync_d = {left_sync_q[SyncStages-2:0], leftFin};
  assign fin_sync    = (state_q == SAVE_WAIT) ? save_sync_q[SyncStages-1]
                                              : left_sync_q[SyncStages-1];
  assign shifts_inc  = shifts_q + 1'b1;

  // cnt_q counts hold cycles in REQ states; in WAIT states it runs through
  // the settle window and then the timeout window without being cleared.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    n_d      = n_q;
    shifts_d = shifts_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (startReq) begin
          n_d      = ({1'b0, amount} > WidthMax) ? WidthMax : {1'b0, amount};
          err_d    = 1'b0;
          shifts_d = '0;
          cnt_d    = '0;
          state_d  = SAVE_REQ;
        end
      end
      SAVE_REQ, LEFT_REQ: begin
        if (cnt_q == HoldLast) begin
          cnt_d   = '0;
          state_d = (state_q == SAVE_REQ) ? SAVE_WAIT : LEFT_WAIT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SAVE_WAIT, LEFT_WAIT: begin
        if (cnt_q < SettleEnd) begin
          cnt_d = cnt_q + 1'b1;
        end else if (fin_sync) begin
          cnt_d = '0;
          if (state_q == SAVE_WAIT) begin
            state_d = (n_q != '0) ? LEFT_REQ : DONE;
          end else begin
            shifts_d = shifts_inc;
            state_d  = (shifts_inc < n_q) ? LEFT_REQ : DONE;
          end
        end else if (cnt_q == CheckLast) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d     = (state_d != IDLE) && (state_d != DONE);
    done_d     = (state_d == DONE);
    save_req_d = (state_d == SAVE_REQ);
    left_req_d = (state_d == LEFT_REQ);
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      n_q         <= '0;
      shifts_q    <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      save_req_q  <= 1'b0;
      left_req_q  <= 1'b0;
      save_sync_q <= '0;
      left_sync_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      n_q         <= n_d;
      shifts_q    <= shifts_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      save_req_q  <= save_req_d;
      left_req_q  <= left_req_d;
      save_sync_q <= save_sync_d;
      left_sync_q <= left_sync_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign error      = err_q;
  assign shiftsDone = shifts_q[AmtWidth-1:0];
  assign saveReq    = save_req_q;
  assign leftReq    = left_req_q;

endmodule
